bp_me_io_cmd_arbiter: RTL and testbench
=======================================

Name: bp_me_io_cmd_arbiter

Overview:
- Shares one host-side I/O command/response channel between num_req_p requesters, e.g. NBF loader, CCE cfg loader and debug injector.
- Replaces the fixed-priority mux in the test harness.
- Grants commands round-robin and holds each grant until the downstream accepts it.
- Records the requester of every issued command in an in-order tag FIFO, so each response returns to its issuer.
- Sits between the loaders and bp_me_cce_to_mem_link_bidir (host link).

Parameters:
- bp_params_p, BP_CFG_FLOWVAR: processor config; gives msg width cce_mem_msg_width_lp (bp_cce_mem_msg_s).
- num_req_p, 2: number of requesters, at least 2.
- max_outstanding_p, 4: maximum number of commands issued but not yet responded to; sets the tag FIFO depth.
- lg_req_lp, derived: BSG_SAFE_CLOG2(num_req_p).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- req_cmd_i  in  num_req_p*msg  per-requester command.
- req_cmd_v_i  in  num_req_p  per-requester command valid.
- req_cmd_yumi_o  out  num_req_p  one-hot accept.
- req_resp_o  out  msg  response; broadcast, qualified by valid.
- req_resp_v_o  out  num_req_p  one-hot response valid.
- req_resp_ready_i  in  num_req_p  per-requester response ready.
- io_cmd_o  out  msg  granted command.
- io_cmd_v_o  out  1  command valid.
- io_cmd_ready_i  in  1  downstream ready.
- io_resp_i  in  msg  downstream response.
- io_resp_v_i  in  1  response valid.
- io_resp_yumi_o  out  1  response consumed.
- busy_o  out  1  any command held or outstanding.

Behaviour:
- Reset is asynchronous: all state clears immediately when reset_n_i=0.
  - Reset state: FSM in IDLE, rr pointer 0, tag FIFO empty, credit count 0.
  - All outputs are 0 during reset, including io_cmd_o (driven '0 when not valid).
- FSM state IDLE:
  - If credits < max_outstanding_p and any req_cmd_v_i is set, pick the first valid requester at or after the rr pointer (wrap-around).
  - Latch the grant index gnt_r and move to HOLD.
  - No combinational grant in IDLE: one cycle of arbitration latency.
- FSM state HOLD:
  - io_cmd_o = req_cmd_i[gnt_r]; io_cmd_v_o = 1.
  - The grant does not change while in HOLD, even if other requesters assert valid. Requesters must keep valid and data stable until yumi.
  - When io_cmd_ready_i=1:
    - req_cmd_yumi_o[gnt_r]=1 in the same cycle.
    - Push gnt_r into the tag FIFO; credits++.
    - rr pointer <= gnt_r+1 mod num_req_p.
    - Return to IDLE.
  - Back-to-back issue from HOLD directly to HOLD is not required; each command takes at least 2 cycles.
- Credit full (credits == max_outstanding_p): IDLE makes no grant. A pop in the same cycle does not unblock IDLE until the next cycle.
- Response path, combinational from the FIFO head h:
  - req_resp_v_o[h] = io_resp_v_i & ~fifo_empty.
  - io_resp_yumi_o = io_resp_v_i & req_resp_ready_i[h] & ~fifo_empty.
  - On yumi: pop the FIFO; credits--.
- Simultaneous push and pop in one cycle: credits unchanged, FIFO stays correct; this includes the case FIFO empty and the response arriving the same cycle as the accept (the pop sees the pre-push state and is invalid).
- io_resp_v_i while the FIFO is empty is a protocol error:
  - Never yumi the response.
  - Non-synth assertion fires.
- Credits are a clog2(max_outstanding_p+1)-bit counter. Assertions: no overflow, no underflow.
- busy_o = (state==HOLD) | (credits != 0).

Test Plan:
- Single requester: req0 valid with msg A, io_cmd_ready_i=1 → io_cmd_v_o high in cycle 2, yumi[0] in cycle 2, credits=1. Response R → req_resp_v_o=2'b01, credits=0.
- Contention fairness: req0 and req1 valid continuously, ready=1, responses returned immediately → grant order 0,1,0,1 over 8 issues, none starved.
- Hold stability: req1 granted, io_cmd_ready_i low for 5 cycles, req0 raises valid at cycle 2 → io_cmd_o stays req1's msg for all 5 cycles. req0 is granted only after req1's yumi.
- Credit limit: max_outstanding_p=4, no responses → exactly 4 issues, busy_o=1, no 5th grant. One response returned → 5th grant appears the cycle after the pop.
- Response routing and backpressure: issue order 1,0,1. Responses arrive with req_resp_ready_i[1]=0 for 3 cycles → io_resp_yumi_o=0 for those 3 cycles. Responses are then delivered to 1,0,1 in that order.
- Async reset mid-operation: reset_n_i dropped while in HOLD with 2 outstanding → outputs 0 immediately, no clock edge needed; after release FSM is IDLE, credits=0, rr pointer=0.

Source files
------------

// File: rtl/bp_me_io_cmd_arbiter_if.sv
// Handshake bundle between the I/O command arbiter, its requesters and the host link.
// The slave modport is the arbiter's view; master is the surrounding harness.
interface bp_me_io_cmd_arbiter_if #(
    parameter int num_req_p   = 2,
    parameter int msg_width_p = 64
);
    logic [num_req_p*msg_width_p-1:0] req_cmd_i;
    logic [num_req_p-1:0]             req_cmd_v_i;
    logic [num_req_p-1:0]             req_cmd_yumi_o;
    logic [msg_width_p-1:0]           req_resp_o;
    logic [num_req_p-1:0]             req_resp_v_o;
    logic [num_req_p-1:0]             req_resp_ready_i;
    logic [msg_width_p-1:0]           io_cmd_o;
    logic                             io_cmd_v_o;
    logic                             io_cmd_ready_i;
    logic [msg_width_p-1:0]           io_resp_i;
    logic                             io_resp_v_i;
    logic                             io_resp_yumi_o;
    logic                             busy_o;

    modport slave (
        input  req_cmd_i, req_cmd_v_i, req_resp_ready_i,
        input  io_cmd_ready_i, io_resp_i, io_resp_v_i,
        output req_cmd_yumi_o, req_resp_o, req_resp_v_o,
        output io_cmd_o, io_cmd_v_o, io_resp_yumi_o, busy_o
    );

    modport master (
        output req_cmd_i, req_cmd_v_i, req_resp_ready_i,
        output io_cmd_ready_i, io_resp_i, io_resp_v_i,
        input  req_cmd_yumi_o, req_resp_o, req_resp_v_o,
        input  io_cmd_o, io_cmd_v_o, io_resp_yumi_o, busy_o
    );
endinterface

// File: rtl/bp_me_io_cmd_arbiter.sv
// Round-robin arbiter sharing one host I/O command/response channel among requesters;
// an in-order tag FIFO steers each response back to the requester that issued it.
//
// state | meaning
// IDLE  | arbitrate among valid requesters when a credit is free, latch the grant
// HOLD  | present the granted command downstream until io_cmd_ready_i accepts it
module bp_me_io_cmd_arbiter #(
    parameter int num_req_p         = 2,
    parameter int max_outstanding_p = 4,
    parameter int msg_width_p       = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    bp_me_io_cmd_arbiter_if.slave   link
);
    localparam int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cred_w_lp = $clog2(max_outstanding_p + 1);
    localparam int ptr_w_lp  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                 state_r, state_n;
    logic [lg_req_lp-1:0]   gnt_r, gnt_n;
    logic [lg_req_lp-1:0]   rr_r, rr_n;
    logic [lg_req_lp-1:0]   pick_idx;
    logic                   pick_v;
    logic                   credit_avail;
    logic                   cmd_v;
    logic [num_req_p-1:0]   cmd_yumi;
    logic                   push, pop;

    logic [cred_w_lp-1:0]   credits_r;
    logic [ptr_w_lp-1:0]    wr_ptr_r, rd_ptr_r;
    logic [lg_req_lp-1:0]   tag_mem_r [max_outstanding_p];
    logic [lg_req_lp-1:0]   head;
    logic                   fifo_empty;
    logic                   resp_fire_v;
    logic [num_req_p-1:0]   resp_v;

    logic [msg_width_p-1:0] cmd_arr [num_req_p];

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign cmd_arr[g] = link.req_cmd_i[g*msg_width_p +: msg_width_p];
    end

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Scan from the highest offset down so the nearest valid requester at or after rr_r wins.
    always_comb begin
        int idx;
        idx      = 0;
        pick_idx = rr_r;
        pick_v   = 1'b0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            idx = int'(rr_r) + k;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (link.req_cmd_v_i[lg_req_lp'(idx)]) begin
                pick_idx = lg_req_lp'(idx);
                pick_v   = 1'b1;
            end
        end
    end

    assign credit_avail = (credits_r < cred_w_lp'(max_outstanding_p));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            gnt_r   <= '0;
            rr_r    <= '0;
        end else begin
            state_r <= state_n;
            gnt_r   <= gnt_n;
            rr_r    <= rr_n;
        end
    end

    always_comb begin
        state_n  = state_r;
        gnt_n    = gnt_r;
        rr_n     = rr_r;
        cmd_v    = 1'b0;
        cmd_yumi = '0;
        push     = 1'b0;
        case (state_r)
            IDLE: begin
                if (credit_avail && pick_v) begin
                    gnt_n   = pick_idx;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                cmd_v = 1'b1;
                if (link.io_cmd_ready_i) begin
                    cmd_yumi[gnt_r] = 1'b1;
                    push            = 1'b1;
                    rr_n            = (gnt_r == lg_req_lp'(num_req_p - 1)) ? '0 : gnt_r + lg_req_lp'(1);
                    state_n         = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign link.io_cmd_v_o     = cmd_v;
    assign link.io_cmd_o       = cmd_v ? cmd_arr[gnt_r] : '0;
    assign link.req_cmd_yumi_o = cmd_yumi;

    // Occupancy of the tag FIFO is exactly the credit count, so empty falls out of it.
    assign fifo_empty  = (credits_r == '0);
    assign head        = tag_mem_r[rd_ptr_r];
    assign resp_fire_v = link.io_resp_v_i & ~fifo_empty;
    assign pop         = resp_fire_v & link.req_resp_ready_i[head];

    always_comb begin
        resp_v = '0;
        if (resp_fire_v) resp_v[head] = 1'b1;
    end

    assign link.req_resp_v_o   = resp_v;
    assign link.req_resp_o     = resp_fire_v ? link.io_resp_i : '0;
    assign link.io_resp_yumi_o = pop;
    assign link.busy_o         = (state_r == HOLD) | ~fifo_empty;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            credits_r <= '0;
            for (int i = 0; i < max_outstanding_p; i++) tag_mem_r[i] <= '0;
        end else begin
            if (push) begin
                tag_mem_r[wr_ptr_r] <= gnt_r;
                wr_ptr_r            <= ptr_inc(wr_ptr_r);
            end
            if (pop) rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({push, pop})
                2'b10:   credits_r <= credits_r + cred_w_lp'(1);
                2'b01:   credits_r <= credits_r - cred_w_lp'(1);
                default: credits_r <= credits_r;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_resp_without_tag: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(link.io_resp_v_i && fifo_empty))
        else $error("io response arrived with no outstanding command");

    a_credit_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(push && !pop && credits_r == cred_w_lp'(max_outstanding_p)))
        else $error("credit counter overflow");

    a_credit_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(pop && !push && fifo_empty))
        else $error("credit counter underflow");
`endif

endmodule

// File: tb/tb_bp_me_io_cmd_arbiter.sv
// Bench for bp_me_io_cmd_arbiter: a vector table for single-cycle behaviour plus
// scoreboarded sequences for fairness, hold stability, credit limit and async reset.
module tb_bp_me_io_cmd_arbiter;
    localparam int NR = 2;
    localparam int MO = 4;
    localparam int W  = 16;
    localparam logic [W-1:0] MSG_A = 16'hA000;
    localparam logic [W-1:0] MSG_B = 16'hB111;
    localparam logic [W-1:0] RSP   = 16'h5A5A;

    logic clk_i     = 1'b0;
    logic reset_n_i = 1'b1;
    always #5 clk_i = ~clk_i;

    bp_me_io_cmd_arbiter_if #(.num_req_p(NR), .msg_width_p(W)) link();

    bp_me_io_cmd_arbiter #(
        .num_req_p(NR),
        .max_outstanding_p(MO),
        .msg_width_p(W)
    ) dut (
        .clk_i(clk_i),
        .reset_n_i(reset_n_i),
        .link(link)
    );

    int total = 0;
    int bad   = 0;
    bit sb_en = 1'b0;
    int cmd_q[$];
    int resp_q[$];

    typedef struct {
        logic [1:0]   req_v;
        logic         io_rdy;
        logic         rsp_v;
        logic [1:0]   rsp_rdy;
        logic         e_cmd_v;
        logic [W-1:0] e_cmd;
        logic [1:0]   e_yumi;
        logic [1:0]   e_rsp_v;
        logic         e_rsp_yumi;
        logic         e_busy;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic [1:0] rv, input logic rdy, input logic sv,
                                input logic [1:0] srdy, input logic cv, input logic [W-1:0] cmd,
                                input logic [1:0] y, input logic [1:0] rsv, input logic ry,
                                input logic b);
        vec_t v;
        v.req_v = rv; v.io_rdy = rdy; v.rsp_v = sv; v.rsp_rdy = srdy;
        v.e_cmd_v = cv; v.e_cmd = cmd; v.e_yumi = y; v.e_rsp_v = rsv;
        v.e_rsp_yumi = ry; v.e_busy = b;
        return v;
    endfunction

    function automatic logic [W-1:0] msg_of(input int r);
        return (r == 0) ? MSG_A : MSG_B;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] rv, input logic rdy, input logic sv, input logic [1:0] srdy);
        link.req_cmd_v_i      = rv;
        link.io_cmd_ready_i   = rdy;
        link.io_resp_v_i      = sv;
        link.req_resp_ready_i = srdy;
    endtask

    task automatic next_cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_v"},    32'(link.io_cmd_v_o), 0);
        chk({tag, "_cmd"},      32'(link.io_cmd_o), 0);
        chk({tag, "_yumi"},     32'(link.req_cmd_yumi_o), 0);
        chk({tag, "_rsp_v"},    32'(link.req_resp_v_o), 0);
        chk({tag, "_rsp"},      32'(link.req_resp_o), 0);
        chk({tag, "_rsp_yumi"}, 32'(link.io_resp_yumi_o), 0);
        chk({tag, "_busy"},     32'(link.busy_o), 0);
    endtask

    // Inputs are held active during reset so that zero outputs prove the gating.
    task automatic do_reset();
        link.req_cmd_i = {MSG_B, MSG_A};
        link.io_resp_i = RSP;
        drive(2'b11, 1'b1, 1'b1, 2'b11);
        reset_n_i = 1'b0;
        #1;
        chk_all_zero("rst");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        reset_n_i = 1'b1;
    endtask

    always @(negedge clk_i) begin
        int e;
        if (sb_en && reset_n_i) begin
            if (link.io_cmd_v_o && link.io_cmd_ready_i) begin
                if (cmd_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_cmd: unexpected accept of %0h with nothing expected", link.io_cmd_o);
                end else begin
                    e = cmd_q.pop_front();
                    chk("sb_cmd_yumi", 32'(link.req_cmd_yumi_o), 32'(1) << e);
                    chk("sb_cmd_msg",  32'(link.io_cmd_o), 32'(msg_of(e)));
                end
            end
            if (link.io_resp_yumi_o) begin
                if (resp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_rsp: unexpected response yumi with nothing expected");
                end else begin
                    e = resp_q.pop_front();
                    chk("sb_rsp_v",   32'(link.req_resp_v_o), 32'(1) << e);
                    chk("sb_rsp_msg", 32'(link.req_resp_o), 32'(RSP));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        //                   req  rdy  rv   srdy | cv  cmd    yumi rspv ry  busy
        tbl[0]  = mk(2'b01, 1, 0, 2'b11, 0, '0,    2'b00, 2'b00, 0, 0);
        tbl[1]  = mk(2'b01, 1, 0, 2'b11, 1, MSG_A, 2'b01, 2'b00, 0, 1);
        tbl[2]  = mk(2'b00, 0, 1, 2'b11, 0, '0,    2'b00, 2'b01, 1, 1);
        tbl[3]  = mk(2'b00, 0, 0, 2'b11, 0, '0,    2'b00, 2'b00, 0, 0);
        tbl[4]  = mk(2'b11, 0, 0, 2'b11, 0, '0,    2'b00, 2'b00, 0, 0);
        tbl[5]  = mk(2'b11, 0, 0, 2'b11, 1, MSG_B, 2'b00, 2'b00, 0, 1);
        tbl[6]  = mk(2'b11, 1, 0, 2'b11, 1, MSG_B, 2'b10, 2'b00, 0, 1);
        tbl[7]  = mk(2'b11, 1, 0, 2'b11, 0, '0,    2'b00, 2'b00, 0, 1);
        tbl[8]  = mk(2'b11, 1, 0, 2'b11, 1, MSG_A, 2'b01, 2'b00, 0, 1);
        tbl[9]  = mk(2'b10, 1, 0, 2'b11, 0, '0,    2'b00, 2'b00, 0, 1);
        tbl[10] = mk(2'b10, 1, 0, 2'b11, 1, MSG_B, 2'b10, 2'b00, 0, 1);
        tbl[11] = mk(2'b00, 0, 1, 2'b01, 0, '0,    2'b00, 2'b10, 0, 1);
        tbl[12] = mk(2'b00, 0, 1, 2'b01, 0, '0,    2'b00, 2'b10, 0, 1);
        tbl[13] = mk(2'b00, 0, 1, 2'b01, 0, '0,    2'b00, 2'b10, 0, 1);
        tbl[14] = mk(2'b00, 0, 1, 2'b11, 0, '0,    2'b00, 2'b10, 1, 1);
        tbl[15] = mk(2'b00, 0, 1, 2'b11, 0, '0,    2'b00, 2'b01, 1, 1);
        tbl[16] = mk(2'b00, 0, 1, 2'b11, 0, '0,    2'b00, 2'b10, 1, 1);
        tbl[17] = mk(2'b00, 0, 0, 2'b11, 0, '0,    2'b00, 2'b00, 0, 0);

        link.req_cmd_i = {MSG_B, MSG_A};
        link.io_resp_i = RSP;
        drive(2'b00, 1'b0, 1'b0, 2'b00);
        #2;

        do_reset();
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].req_v, tbl[i].io_rdy, tbl[i].rsp_v, tbl[i].rsp_rdy);
            sample();
            chk($sformatf("row%0d_cmd_v", i),    32'(link.io_cmd_v_o),     32'(tbl[i].e_cmd_v));
            chk($sformatf("row%0d_cmd", i),      32'(link.io_cmd_o),       32'(tbl[i].e_cmd));
            chk($sformatf("row%0d_yumi", i),     32'(link.req_cmd_yumi_o), 32'(tbl[i].e_yumi));
            chk($sformatf("row%0d_rsp_v", i),    32'(link.req_resp_v_o),   32'(tbl[i].e_rsp_v));
            chk($sformatf("row%0d_rsp_yumi", i), 32'(link.io_resp_yumi_o), 32'(tbl[i].e_rsp_yumi));
            chk($sformatf("row%0d_busy", i),     32'(link.busy_o),         32'(tbl[i].e_busy));
            chk($sformatf("row%0d_rsp", i),      32'(link.req_resp_o),
                (tbl[i].e_rsp_v != 2'b00) ? 32'(RSP) : 0);
            next_cyc();
        end

        // Fairness: both requesters always valid, each response returned right away.
        do_reset();
        sb_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_q.push_back(i % 2);
            resp_q.push_back(i % 2);
        end
        for (int i = 0; i < 8; i++) begin
            drive(2'b11, 1'b1, (i > 0), 2'b11);
            sample();
            chk("fair_idle_v", 32'(link.io_cmd_v_o), 0);
            next_cyc();
            drive(2'b11, 1'b1, 1'b0, 2'b11);
            sample();
            chk("fair_hold_v", 32'(link.io_cmd_v_o), 1);
            next_cyc();
        end
        drive(2'b00, 1'b0, 1'b1, 2'b11);
        sample();
        chk("fair_last_rsp", 32'(link.io_resp_yumi_o), 1);
        next_cyc();
        drive(2'b00, 1'b0, 1'b0, 2'b11);
        sample();
        chk("fair_busy_end", 32'(link.busy_o), 0);
        chk("fair_cmdq_left", 32'(cmd_q.size()), 0);
        chk("fair_rspq_left", 32'(resp_q.size()), 0);
        next_cyc();
        sb_en = 1'b0;

        // Hold stability: req1 held with ready low while req0 raises valid.
        do_reset();
        sb_en = 1'b1;
        cmd_q.push_back(1);  cmd_q.push_back(0);
        resp_q.push_back(1); resp_q.push_back(0);
        drive(2'b10, 1'b0, 1'b0, 2'b11);
        sample();
        chk("hold_idle_v", 32'(link.io_cmd_v_o), 0);
        next_cyc();
        for (int k = 1; k <= 5; k++) begin
            drive((k >= 2) ? 2'b11 : 2'b10, 1'b0, 1'b0, 2'b11);
            sample();
            chk($sformatf("hold%0d_v", k),    32'(link.io_cmd_v_o), 1);
            chk($sformatf("hold%0d_cmd", k),  32'(link.io_cmd_o), 32'(MSG_B));
            chk($sformatf("hold%0d_yumi", k), 32'(link.req_cmd_yumi_o), 0);
            next_cyc();
        end
        drive(2'b11, 1'b1, 1'b0, 2'b11);
        sample();
        chk("hold_accept_yumi", 32'(link.req_cmd_yumi_o), 2);
        next_cyc();
        drive(2'b01, 1'b1, 1'b0, 2'b11);
        sample();
        chk("hold_rearb_v", 32'(link.io_cmd_v_o), 0);
        next_cyc();
        drive(2'b01, 1'b1, 1'b0, 2'b11);
        sample();
        chk("hold_req0_cmd", 32'(link.io_cmd_o), 32'(MSG_A));
        next_cyc();
        for (int k = 0; k < 2; k++) begin
            drive(2'b00, 1'b0, 1'b1, 2'b11);
            sample();
            next_cyc();
        end
        drive(2'b00, 1'b0, 1'b0, 2'b11);
        sample();
        chk("hold_busy_end", 32'(link.busy_o), 0);
        chk("hold_cmdq_left", 32'(cmd_q.size()), 0);
        chk("hold_rspq_left", 32'(resp_q.size()), 0);
        next_cyc();
        sb_en = 1'b0;

        // Credit limit: four issues saturate the credits; one pop lets a fifth through a cycle later.
        do_reset();
        sb_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cmd_q.push_back(0);
            resp_q.push_back(0);
        end
        acc = 0;
        for (int c = 0; c < 14; c++) begin
            drive(2'b01, 1'b1, 1'b0, 2'b11);
            sample();
            if (link.io_cmd_v_o && link.io_cmd_ready_i) acc++;
            next_cyc();
        end
        chk("cred_issues", 32'(acc), 4);
        chk("cred_busy", 32'(link.busy_o), 1);
        chk("cred_no_5th", 32'(link.io_cmd_v_o), 0);
        drive(2'b01, 1'b1, 1'b1, 2'b11);
        sample();
        chk("cred_pop_v", 32'(link.io_cmd_v_o), 0);
        chk("cred_pop_yumi", 32'(link.io_resp_yumi_o), 1);
        next_cyc();
        drive(2'b01, 1'b1, 1'b0, 2'b11);
        sample();
        chk("cred_after_pop_v", 32'(link.io_cmd_v_o), 0);
        next_cyc();
        drive(2'b01, 1'b1, 1'b0, 2'b11);
        sample();
        chk("cred_5th_v", 32'(link.io_cmd_v_o), 1);
        next_cyc();
        for (int k = 0; k < 4; k++) begin
            drive(2'b00, 1'b0, 1'b1, 2'b11);
            sample();
            next_cyc();
        end
        drive(2'b00, 1'b0, 1'b0, 2'b11);
        sample();
        chk("cred_busy_end", 32'(link.busy_o), 0);
        chk("cred_cmdq_left", 32'(cmd_q.size()), 0);
        chk("cred_rspq_left", 32'(resp_q.size()), 0);
        next_cyc();
        sb_en = 1'b0;

        // Async reset while holding a grant with two outstanding and rr pointer at 1.
        do_reset();
        drive(2'b10, 1'b1, 1'b0, 2'b11); sample(); next_cyc();
        drive(2'b10, 1'b1, 1'b0, 2'b11); sample();
        chk("ar_yumi1", 32'(link.req_cmd_yumi_o), 2);
        next_cyc();
        drive(2'b01, 1'b1, 1'b0, 2'b11); sample(); next_cyc();
        drive(2'b01, 1'b1, 1'b0, 2'b11); sample();
        chk("ar_yumi0", 32'(link.req_cmd_yumi_o), 1);
        next_cyc();
        drive(2'b11, 1'b0, 1'b0, 2'b11); sample(); next_cyc();
        drive(2'b11, 1'b1, 1'b1, 2'b11);
        #1;
        chk("ar_pre_cmd_v", 32'(link.io_cmd_v_o), 1);
        chk("ar_pre_rsp_v", 32'(link.req_resp_v_o), 2);
        #1;
        reset_n_i = 1'b0;
        #1;
        chk_all_zero("ar_async");
        @(posedge clk_i);
        #1;
        drive(2'b00, 1'b0, 1'b0, 2'b11);
        reset_n_i = 1'b1;
        sample();
        chk("ar_busy_after", 32'(link.busy_o), 0);
        next_cyc();
        drive(2'b11, 1'b1, 1'b0, 2'b11); sample();
        chk("ar_idle_v", 32'(link.io_cmd_v_o), 0);
        next_cyc();
        drive(2'b11, 1'b1, 1'b0, 2'b11); sample();
        chk("ar_rr0_cmd", 32'(link.io_cmd_o), 32'(MSG_A));
        chk("ar_rr0_yumi", 32'(link.req_cmd_yumi_o), 1);
        next_cyc();
        drive(2'b00, 1'b0, 1'b1, 2'b11); sample();
        chk("ar_rsp_v", 32'(link.req_resp_v_o), 1);
        chk("ar_rsp_yumi", 32'(link.io_resp_yumi_o), 1);
        next_cyc();
        drive(2'b00, 1'b0, 1'b0, 2'b11); sample();
        chk("ar_busy_end", 32'(link.busy_o), 0);
        next_cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
